// File: rtl/adbg_lint_arbiter.sv
// Two-master to one-slave LINT arbiter with an in-order ID FIFO that routes each response back to its issuer.
// Optional build macro ADBG_LINT_ARB_FIXED_PRIO_EN: master 0 always wins; otherwise round-robin.
module adbg_lint_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned AUX_WIDTH       = 6,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [1:0]                            m_req_i,
  input  logic [1:0][ADDR_WIDTH-1:0]            m_add_i,
  input  logic [1:0]                            m_wen_i,
  input  logic [1:0][DATA_WIDTH-1:0]            m_wdata_i,
  input  logic [1:0][DATA_WIDTH/8-1:0]          m_be_i,
  input  logic [1:0][AUX_WIDTH-1:0]             m_aux_i,
  output logic [1:0]                            m_gnt_o,
  output logic [1:0]                            m_r_valid_o,
  output logic [DATA_WIDTH-1:0]                 m_r_rdata_o,
  output logic                                  m_r_opc_o,
  output logic                                  m_r_aux_o,
  output logic                                  lint_req_o,
  output logic [ADDR_WIDTH-1:0]                 lint_add_o,
  output logic                                  lint_wen_o,
  output logic [DATA_WIDTH-1:0]                 lint_wdata_o,
  output logic [DATA_WIDTH/8-1:0]               lint_be_o,
  output logic [AUX_WIDTH-1:0]                  lint_aux_o,
  input  logic                                  lint_gnt_i,
  input  logic                                  lint_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                 lint_r_rdata_i,
  input  logic                                  lint_r_opc_i,
  input  logic                                  lint_r_aux_i,
  output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_o,
  output logic                                  resp_err_o
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                       rr_q, rr_d;
  logic [MAX_OUTSTANDING-1:0] id_q, id_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic sel;
  logic full;
  logic has_out;
  logic req_c;
  logic accept;
  logic pop;
  logic head;

  // Winner selection; with nothing requested the payload follows the priority master
  always_comb begin
    sel = rr_q;
`ifdef ADBG_LINT_ARB_FIXED_PRIO_EN
    case (m_req_i)
      2'b01, 2'b11: sel = 1'b0;
      2'b10:        sel = 1'b1;
      default:      sel = rr_q;
    endcase
`else
    case (m_req_i)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      default: sel = rr_q;
    endcase
`endif
  end

  assign full    = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign has_out = (cnt_q != '0);
  assign req_c   = (|m_req_i) & ~full & ~rst_i;
  assign accept  = req_c & lint_gnt_i;
  assign pop     = lint_r_valid_i & has_out & ~rst_i;
  assign head    = id_q[rd_ptr_q];

  assign lint_req_o   = req_c;
  assign lint_add_o   = m_add_i[sel];
  assign lint_wen_o   = m_wen_i[sel];
  assign lint_wdata_o = m_wdata_i[sel];
  assign lint_be_o    = m_be_i[sel];
  assign lint_aux_o   = m_aux_i[sel];

  assign m_gnt_o     = accept ? (sel  ? 2'b10 : 2'b01) : 2'b00;
  assign m_r_valid_o = pop    ? (head ? 2'b10 : 2'b01) : 2'b00;
  assign m_r_rdata_o = lint_r_rdata_i;
  assign m_r_opc_o   = lint_r_opc_i;
  assign m_r_aux_o   = lint_r_aux_i;

  assign outstanding_o = cnt_q;
  assign resp_err_o    = err_q;

  // Next-state: FIFO push/pop, occupancy, priority rotation, sticky stray-response flag
  always_comb begin
    rr_d     = rr_q;
    id_d     = id_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    if (accept) begin
      id_d[wr_ptr_q] = sel;
      wr_ptr_d       = wr_ptr_q + PTR_W'(1);
`ifdef ADBG_LINT_ARB_FIXED_PRIO_EN
      rr_d           = 1'b0;
`else
      rr_d           = ~sel;
`endif
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (lint_r_valid_i && !has_out) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q     <= 1'b0;
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      id_q     <= id_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_adbg_lint_arbiter.sv
// Self-checking bench for adbg_lint_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_adbg_lint_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 64;
  localparam int unsigned BW   = DW / 8;
  localparam int unsigned XW   = 6;
  localparam int unsigned MAXO = 4;
`ifdef ADBG_LINT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b1;
  logic [1:0]             m_req_i = '0;
  logic [1:0][AW-1:0]     m_add_i = '0;
  logic [1:0]             m_wen_i = '0;
  logic [1:0][DW-1:0]     m_wdata_i = '0;
  logic [1:0][BW-1:0]     m_be_i = '0;
  logic [1:0][XW-1:0]     m_aux_i = '0;
  logic [1:0]             m_gnt_o;
  logic [1:0]             m_r_valid_o;
  logic [DW-1:0]          m_r_rdata_o;
  logic                   m_r_opc_o;
  logic                   m_r_aux_o;
  logic                   lint_req_o;
  logic [AW-1:0]          lint_add_o;
  logic                   lint_wen_o;
  logic [DW-1:0]          lint_wdata_o;
  logic [BW-1:0]          lint_be_o;
  logic [XW-1:0]          lint_aux_o;
  logic                   lint_gnt_i = 1'b0;
  logic                   lint_r_valid_i = 1'b0;
  logic [DW-1:0]          lint_r_rdata_i = '0;
  logic                   lint_r_opc_i = 1'b0;
  logic                   lint_r_aux_i = 1'b0;
  logic [2:0]             outstanding_o;
  logic                   resp_err_o;

  adbg_lint_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AUX_WIDTH(XW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_add_i(m_add_i), .m_wen_i(m_wen_i), .m_wdata_i(m_wdata_i),
    .m_be_i(m_be_i), .m_aux_i(m_aux_i), .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o),
    .m_r_rdata_o(m_r_rdata_o), .m_r_opc_o(m_r_opc_o), .m_r_aux_o(m_r_aux_o),
    .lint_req_o(lint_req_o), .lint_add_o(lint_add_o), .lint_wen_o(lint_wen_o),
    .lint_wdata_o(lint_wdata_o), .lint_be_o(lint_be_o), .lint_aux_o(lint_aux_o),
    .lint_gnt_i(lint_gnt_i), .lint_r_valid_i(lint_r_valid_i), .lint_r_rdata_i(lint_r_rdata_i),
    .lint_r_opc_i(lint_r_opc_i), .lint_r_aux_i(lint_r_aux_i),
    .outstanding_o(outstanding_o), .resp_err_o(resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of issuing masters, priority holder, sticky error
  int   q[$];
  int   rr = 0;
  bit   merr = 1'b0;
  bit   e_req;
  int   e_sel;
  logic [1:0] e_gnt;
  logic [1:0] e_rv;

  function automatic void calc();
    if (m_req_i == 2'b11)      e_sel = FIXED ? 0 : rr;
    else if (m_req_i == 2'b10) e_sel = 1;
    else if (m_req_i == 2'b01) e_sel = 0;
    else                       e_sel = rr;
    e_req = (m_req_i != 2'b00) && (q.size() < MAXO);
    e_gnt = (e_req && lint_gnt_i) ? ((e_sel == 1) ? 2'b10 : 2'b01) : 2'b00;
    e_rv  = (lint_r_valid_i && q.size() > 0) ? ((q[0] == 1) ? 2'b10 : 2'b01) : 2'b00;
  endfunction

  task automatic tick();
    calc();
    @(posedge clk_i);
    if (lint_r_valid_i) begin
      if (q.size() > 0) void'(q.pop_front());
      else merr = 1'b1;
    end
    if (e_gnt != 2'b00) begin
      q.push_back(e_sel);
      rr = FIXED ? 0 : 1 - e_sel;
    end
    #1;
  endtask

  task automatic set_idle();
    m_req_i = 2'b00;
    lint_gnt_i = 1'b0;
    lint_r_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    set_idle();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    q.delete();
    rr = 0;
    merr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    m_req_i = 2'b11; lint_gnt_i = 1'b1; lint_r_valid_i = 1'b1;
    #2;
    vectors++; if (lint_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", lint_req_o); end
    vectors++; if (m_gnt_o !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", m_gnt_o); end
    vectors++; if (m_r_valid_o !== 2'b00) begin miscompares++; $display("FAIL reset_rvalid: got %b want 00", m_r_valid_o); end
    @(posedge clk_i); #1;
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", outstanding_o); end
    vectors++; if (resp_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", resp_err_o); end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    m_req_i = 2'b01; m_wen_i = 2'b00;
    m_add_i[0] = 32'h1000_0040; m_wdata_i[0] = 64'hDEAD_BEEF_0123_4567; m_be_i[0] = 8'hFF;
    m_add_i[1] = 32'h2222_2222; m_wdata_i[1] = 64'h0;
    lint_gnt_i = 1'b1;
    #2;
    vectors++; if (lint_req_o !== 1'b1) begin miscompares++; $display("FAIL single_req: got %b want 1", lint_req_o); end
    vectors++; if (lint_add_o !== 32'h1000_0040) begin miscompares++; $display("FAIL single_add: got %h want 10000040", lint_add_o); end
    vectors++; if (lint_wdata_o !== 64'hDEAD_BEEF_0123_4567) begin miscompares++; $display("FAIL single_wdata: got %h want deadbeef01234567", lint_wdata_o); end
    vectors++; if (lint_be_o !== 8'hFF) begin miscompares++; $display("FAIL single_be: got %h want ff", lint_be_o); end
    vectors++; if (m_gnt_o !== 2'b01) begin miscompares++; $display("FAIL single_gnt: got %b want 01", m_gnt_o); end
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL single_cnt0: got %0d want 0", outstanding_o); end
    tick();
    m_req_i = 2'b00; lint_gnt_i = 1'b0;
    vectors++; if (outstanding_o !== 3'd1) begin miscompares++; $display("FAIL single_cnt1: got %0d want 1", outstanding_o); end
    lint_r_valid_i = 1'b1; lint_r_rdata_i = 64'h0123_4567_89AB_CDEF; lint_r_opc_i = 1'b1;
    #2;
    vectors++; if (m_r_valid_o !== 2'b01) begin miscompares++; $display("FAIL single_rvalid: got %b want 01", m_r_valid_o); end
    vectors++; if (m_r_rdata_o !== 64'h0123_4567_89AB_CDEF) begin miscompares++; $display("FAIL single_rdata: got %h want 0123456789abcdef", m_r_rdata_o); end
    vectors++; if (m_r_opc_o !== 1'b1) begin miscompares++; $display("FAIL single_opc: got %b want 1", m_r_opc_o); end
    tick();
    lint_r_valid_i = 1'b0; lint_r_opc_i = 1'b0;
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL single_cnt_end: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_round_robin();
    int prev;
    int exp;
    do_reset();
    prev = 0;
    m_req_i = 2'b11; lint_gnt_i = 1'b1;
    m_add_i[0] = 32'hA000_0000; m_add_i[1] = 32'hB000_0001;
    for (int i = 0; i < 6; i++) begin
      lint_r_valid_i = (i > 0);
      #2;
      exp = FIXED ? 0 : i % 2;
      vectors++; if (m_gnt_o !== ((exp == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr_gnt[%0d]: got %b want master %0d", i, m_gnt_o, exp); end
      vectors++; if (lint_add_o !== ((exp == 1) ? 32'hB000_0001 : 32'hA000_0000)) begin miscompares++; $display("FAIL rr_add[%0d]: got %h", i, lint_add_o); end
      if (i > 0) begin
        vectors++; if (m_r_valid_o !== ((prev == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr_rvalid[%0d]: got %b want master %0d", i, m_r_valid_o, prev); end
        vectors++; if (outstanding_o !== 3'd1) begin miscompares++; $display("FAIL rr_cnt[%0d]: got %0d want 1", i, outstanding_o); end
      end
      prev = exp;
      tick();
    end
    m_req_i = 2'b00; lint_gnt_i = 1'b0; lint_r_valid_i = 1'b1;
    #2;
    vectors++; if (m_r_valid_o !== ((prev == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr_last_rvalid: got %b want master %0d", m_r_valid_o, prev); end
    tick();
    lint_r_valid_i = 1'b0;
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL rr_cnt_end: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_full();
    do_reset();
    m_req_i = 2'b10; lint_gnt_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      vectors++; if (m_gnt_o !== ((i < 4) ? 2'b10 : 2'b00)) begin miscompares++; $display("FAIL full_gnt[%0d]: got %b", i, m_gnt_o); end
      vectors++; if (lint_req_o !== (i < 4)) begin miscompares++; $display("FAIL full_req[%0d]: got %b", i, lint_req_o); end
      tick();
    end
    vectors++; if (outstanding_o !== 3'd4) begin miscompares++; $display("FAIL full_cnt: got %0d want 4", outstanding_o); end
    lint_r_valid_i = 1'b1;
    #2;
    vectors++; if (lint_req_o !== 1'b0) begin miscompares++; $display("FAIL full_pop_req: got %b want 0", lint_req_o); end
    vectors++; if (m_r_valid_o !== 2'b10) begin miscompares++; $display("FAIL full_pop_rvalid: got %b want 10", m_r_valid_o); end
    tick();
    lint_r_valid_i = 1'b0;
    #2;
    vectors++; if (m_gnt_o !== 2'b10) begin miscompares++; $display("FAIL full_regrant: got %b want 10", m_gnt_o); end
    vectors++; if (outstanding_o !== 3'd3) begin miscompares++; $display("FAIL full_cnt3: got %0d want 3", outstanding_o); end
    tick();
    vectors++; if (outstanding_o !== 3'd4) begin miscompares++; $display("FAIL full_cnt4: got %0d want 4", outstanding_o); end
    m_req_i = 2'b00; lint_gnt_i = 1'b0; lint_r_valid_i = 1'b1;
    repeat (4) tick();
    lint_r_valid_i = 1'b0;
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL full_drain: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_accept_pop();
    do_reset();
    m_req_i = 2'b01; lint_gnt_i = 1'b1;
    tick(); tick();
    vectors++; if (outstanding_o !== 3'd2) begin miscompares++; $display("FAIL ap_cnt_pre: got %0d want 2", outstanding_o); end
    lint_r_valid_i = 1'b1;
    #2;
    vectors++; if (m_gnt_o !== 2'b01) begin miscompares++; $display("FAIL ap_gnt: got %b want 01", m_gnt_o); end
    vectors++; if (m_r_valid_o !== 2'b01) begin miscompares++; $display("FAIL ap_rvalid: got %b want 01", m_r_valid_o); end
    tick();
    vectors++; if (outstanding_o !== 3'd2) begin miscompares++; $display("FAIL ap_cnt_post: got %0d want 2", outstanding_o); end
    m_req_i = 2'b00; lint_gnt_i = 1'b0;
    tick(); tick();
    lint_r_valid_i = 1'b0;
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL ap_drain: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_stray_resp();
    do_reset();
    lint_r_valid_i = 1'b1;
    #2;
    vectors++; if (m_r_valid_o !== 2'b00) begin miscompares++; $display("FAIL stray_rvalid: got %b want 00", m_r_valid_o); end
    vectors++; if (resp_err_o !== 1'b0) begin miscompares++; $display("FAIL stray_err_pre: got %b want 0", resp_err_o); end
    tick();
    lint_r_valid_i = 1'b0;
    vectors++; if (resp_err_o !== 1'b1) begin miscompares++; $display("FAIL stray_err_set: got %b want 1", resp_err_o); end
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL stray_cnt: got %0d want 0", outstanding_o); end
    repeat (3) tick();
    vectors++; if (resp_err_o !== 1'b1) begin miscompares++; $display("FAIL stray_err_hold: got %b want 1", resp_err_o); end
    do_reset();
    vectors++; if (resp_err_o !== 1'b0) begin miscompares++; $display("FAIL stray_err_clr: got %b want 0", resp_err_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_req_i = 2'b01; lint_gnt_i = 1'b1;
    repeat (3) tick();
    vectors++; if (outstanding_o !== 3'd3) begin miscompares++; $display("FAIL rmid_cnt3: got %0d want 3", outstanding_o); end
    rst_i = 1'b1;
    #1;
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL rmid_cnt0: got %0d want 0", outstanding_o); end
    vectors++; if (lint_req_o !== 1'b0) begin miscompares++; $display("FAIL rmid_req: got %b want 0", lint_req_o); end
    vectors++; if (m_gnt_o !== 2'b00) begin miscompares++; $display("FAIL rmid_gnt: got %b want 00", m_gnt_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    q.delete(); rr = 0; merr = 1'b0;
    #1;
    vectors++; if (m_gnt_o !== 2'b01) begin miscompares++; $display("FAIL rmid_regrant: got %b want 01", m_gnt_o); end
    tick();
    m_req_i = 2'b00; lint_gnt_i = 1'b0;
    vectors++; if (outstanding_o !== 3'd1) begin miscompares++; $display("FAIL rmid_cnt1: got %0d want 1", outstanding_o); end
    lint_r_valid_i = 1'b1;
    tick(); tick();
    lint_r_valid_i = 1'b0;
    vectors++; if (outstanding_o !== 3'd0) begin miscompares++; $display("FAIL rmid_cnt_end: got %0d want 0", outstanding_o); end
    vectors++; if (resp_err_o !== 1'b1) begin miscompares++; $display("FAIL rmid_stray_err: got %b want 1", resp_err_o); end
  endtask

  task automatic test_random();
    int sel_add;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      m_req_i = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        m_add_i[k]   = $urandom;
        m_wdata_i[k] = {$urandom, $urandom};
        m_be_i[k]    = 8'($urandom);
        m_aux_i[k]   = 6'($urandom);
      end
      m_wen_i        = 2'($urandom);
      lint_gnt_i     = ($urandom_range(0, 3) != 0);
      lint_r_valid_i = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      lint_r_rdata_i = {$urandom, $urandom};
      lint_r_aux_i   = 1'($urandom);
      #2;
      calc();
      sel_add = e_sel;
      vectors++; if (lint_req_o !== e_req) begin miscompares++; $display("FAIL rnd_req[%0d]: got %b want %b", n, lint_req_o, e_req); end
      vectors++; if (m_gnt_o !== e_gnt) begin miscompares++; $display("FAIL rnd_gnt[%0d]: got %b want %b", n, m_gnt_o, e_gnt); end
      vectors++; if (m_r_valid_o !== e_rv) begin miscompares++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", n, m_r_valid_o, e_rv); end
      vectors++; if (outstanding_o !== 3'(q.size())) begin miscompares++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, outstanding_o, q.size()); end
      vectors++; if (resp_err_o !== merr) begin miscompares++; $display("FAIL rnd_err[%0d]: got %b want %b", n, resp_err_o, merr); end
      vectors++; if (m_r_rdata_o !== lint_r_rdata_i || m_r_aux_o !== lint_r_aux_i) begin miscompares++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, m_r_rdata_o, lint_r_rdata_i); end
      if (e_req) begin
        vectors++;
        if (lint_add_o !== m_add_i[sel_add] || lint_wdata_o !== m_wdata_i[sel_add] ||
            lint_aux_o !== m_aux_i[sel_add] || lint_be_o !== m_be_i[sel_add] || lint_wen_o !== m_wen_i[sel_add]) begin
          miscompares++; $display("FAIL rnd_payload[%0d]: got add %h want %h (master %0d)", n, lint_add_o, m_add_i[sel_add], sel_add);
        end
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_full();
    test_accept_pop();
    test_stray_resp();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adbg_lint_arbiter.md
Name: adbg_lint_arbiter

Overview:
Two-master to one-slave LINT arbiter that shares the debug LINT port between the JTAG debug LINT module (master 0) and a second requester (master 1, e.g. a debug DMA/sysbus helper).
- Arbitrates requests round-robin and forwards the winner's payload to the slave.
- Tracks outstanding transactions in an ID FIFO so in-order responses return to the issuing master.
- Sits between the debug module instances and the SoC LINT interconnect, on the system clock domain.

Parameters:
ADDR_WIDTH, 32, LINT address width
DATA_WIDTH, 64, LINT data width; byte enables are DATA_WIDTH/8
AUX_WIDTH, 6, request aux width
MAX_OUTSTANDING, 4, max accepted-but-unanswered transactions; power of 2, >=2

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
m_req_i  in  2  per-master request
m_add_i  in  2xADDR_WIDTH  per-master address
m_wen_i  in  2  per-master write-enable (1 = read, LINT convention)
m_wdata_i  in  2xDATA_WIDTH  per-master write data
m_be_i  in  2x(DATA_WIDTH/8)  per-master byte enables
m_aux_i  in  2xAUX_WIDTH  per-master aux
m_gnt_o  out  2  per-master grant
m_r_valid_o  out  2  per-master response valid
m_r_rdata_o  out  DATA_WIDTH  response data, broadcast to both masters
m_r_opc_o  out  1  response error/opcode, broadcast
m_r_aux_o  out  1  response aux, broadcast
lint_req_o  out  1  slave request
lint_add_o  out  ADDR_WIDTH  slave address
lint_wen_o  out  1  slave write-enable
lint_wdata_o  out  DATA_WIDTH  slave write data
lint_be_o  out  DATA_WIDTH/8  slave byte enables
lint_aux_o  out  AUX_WIDTH  slave aux
lint_gnt_i  in  1  slave grant
lint_r_valid_i  in  1  slave response valid
lint_r_rdata_i  in  DATA_WIDTH  slave read data
lint_r_opc_i  in  1  slave response opcode
lint_r_aux_i  in  1  slave response aux
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current outstanding count
resp_err_o  out  1  sticky: response received with no outstanding transaction

Behaviour:
- State: rr_q (1 bit, master with priority), ID FIFO (MAX_OUTSTANDING x 1 bit, wr/rd pointers), cnt_q, err_q. All reset to 0.
- While rst_i is high: lint_req_o=0, m_gnt_o=0, m_r_valid_o=0, outstanding_o=0, resp_err_o=0.
- full = (cnt_q == MAX_OUTSTANDING), from registered count only; no same-cycle bypass.
- Selection (combinational):
  - Only one master requesting: that master wins.
  - Both requesting: master rr_q wins.
- Request path:
  - lint_req_o = |m_req_i & !full.
  - Payload muxed from the selected master; when nothing is requested, payload selects master rr_q.
- Grant: m_gnt_o[sel] = lint_gnt_i & lint_req_o; the other bit is 0. Never both bits at once.
- Accept = lint_req_o & lint_gnt_i. On accept:
  - Push sel into the ID FIFO.
  - rr_q <= ~sel.
  - rr_q changes only on accept, so selection is stable while a master waits with an unchanged request set.
- Masters hold req and payload stable until granted; the arbiter does not check this.
- Responses:
  - lint_r_valid_i with cnt_q>0: m_r_valid_o[head]=1 in the same cycle (combinational, 0 added latency); pop the FIFO.
  - rdata/opc/aux pass through unregistered to both masters.
  - Responses are in order; the slave returns r_valid no earlier than the cycle after gnt.
- lint_r_valid_i with cnt_q==0: no m_r_valid_o, no pop; err_q <= 1 (sticky until reset).
- Count update:
  - Accept only: cnt+1.
  - Pop only: cnt-1.
  - Accept and pop in the same cycle: cnt unchanged, pointers both advance.
- Full: no request reaches the slave; a pop in that cycle frees a slot from the next cycle.
- Pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-transaction: all state clears and in-flight responses are lost. Later stray responses set resp_err_o.

Optional Feature:
ADBG_LINT_ARB_FIXED_PRIO_EN
- Defined: master 0 (JTAG debug) always wins when requesting; rr_q is held at 0.
- Undefined: round-robin as above.
- FIFO, count, and error behaviour are identical in both cases.

Test Plan:
- Single master 0 write, add=0x1000_0040, wdata=0xDEAD_BEEF_0123_4567, be=0xFF, gnt same cycle -> lint_add_o=0x1000_0040, m_gnt_o=2'b01, outstanding_o 0->1; r_valid next cycle -> m_r_valid_o=2'b01, outstanding_o=0.
- Both masters request continuously, gnt always 1, r_valid one cycle after each gnt -> grant order 0,1,0,1; each r_valid routed to the issuer. With ADBG_LINT_ARB_FIXED_PRIO_EN -> master 0 granted every cycle, master 1 never.
- gnt always 1, r_valid held 0, master 1 requests 6 times -> 4 grants, outstanding_o=4, lint_req_o=0; one r_valid -> next cycle one more grant.
- Accept and r_valid in the same cycle at outstanding_o=2 -> stays 2; ID order preserved across pointer wrap (>=8 transactions).
- r_valid with outstanding_o=0 -> m_r_valid_o=0, resp_err_o=1 and held; rst_i pulse -> resp_err_o=0.
- rst_i asserted with 3 outstanding -> outstanding_o=0, lint_req_o=0 immediately; after release, a new request is granted normally.
